// File: rtl/mat_serialize.sv
// ============================================================================
// mat_serialize
// Captures a flat row-major matrix in one cycle and streams it one element per
// valid/ready handshake with row/column tags and a last flag.
// Build option: define MAT_SERIALIZE_COL_MAJOR_EN for column-major emission.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_serialize #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int WIDTH = 8,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [ROWS*COLS*WIDTH-1:0]  mat_in,
    output logic                        load_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [ROW_W-1:0]            out_row,
    output logic [COL_W-1:0]            out_col,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic             SINGLE   = (N == 1);

    generate
        if (ROWS < 1 || COLS < 1) begin : g_bad_dims
            $fatal(1, "mat_serialize: ROWS=%0d COLS=%0d, both must be >= 1", ROWS, COLS);
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mem [N];
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [WIDTH-1:0]   r_data;
    logic               r_last;
    logic               r_valid;
    logic               r_load_ready;
    logic               r_busy;

    logic [ROW_W-1:0]   w_next_row;
    logic [COL_W-1:0]   w_next_col;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_final;
    logic               w_next_last;

    // Position of the element that follows the one currently presented.
    always_comb begin
        w_next_row = r_row;
        w_next_col = r_col;
`ifdef MAT_SERIALIZE_COL_MAJOR_EN
        if (r_row == ROW_LAST) begin
            w_next_row = '0;
            w_next_col = r_col + 1'b1;
        end else begin
            w_next_row = r_row + 1'b1;
        end
`else
        if (r_col == COL_LAST) begin
            w_next_col = '0;
            w_next_row = r_row + 1'b1;
        end else begin
            w_next_col = r_col + 1'b1;
        end
`endif
        w_final     = (r_row == ROW_LAST) && (r_col == COL_LAST);
        w_next_last = (w_next_row == ROW_LAST) && (w_next_col == COL_LAST);
        w_next_idx  = IDX_W'(int'(w_next_row) * COLS + int'(w_next_col));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_valid      <= 1'b0;
            r_load_ready <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        for (int i = 0; i < N; i++) r_mem[i] <= mat_in[i*WIDTH +: WIDTH];
                        r_row        <= '0;
                        r_col        <= '0;
                        r_data       <= mat_in[WIDTH-1:0];
                        r_last       <= SINGLE;
                        r_valid      <= 1'b1;
                        r_load_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (w_final) begin
                            r_row        <= '0;
                            r_col        <= '0;
                            r_data       <= '0;
                            r_last       <= 1'b0;
                            r_valid      <= 1'b0;
                            r_load_ready <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_row  <= w_next_row;
                            r_col  <= w_next_col;
                            r_data <= r_mem[w_next_idx];
                            r_last <= w_next_last;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign out_data   = r_data;
    assign out_row    = r_row;
    assign out_col    = r_col;
    assign out_last   = r_last;
    assign out_valid  = r_valid;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mat_serialize.sv
// ============================================================================
// tb_mat_serialize
// Directed bench: a queue-based stream model checked every cycle plus literal
// expectations for the 2x3 and 1x1 matrices.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_serialize;

    localparam int ROWS = 2;
    localparam int COLS = 3;

    logic        clk;
    logic        reset;
    logic        load;
    logic [47:0] mat_in;
    logic        load_ready;
    logic [7:0]  out_data;
    logic [0:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic        s_load;
    logic [7:0]  s_mat;
    logic        s_load_ready;
    logic [7:0]  s_data;
    logic [0:0]  s_row;
    logic [0:0]  s_col;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic        s_busy;

    int n_vec = 0;
    int n_err = 0;

    mat_serialize #(.ROWS(ROWS), .COLS(COLS), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .load(load), .mat_in(mat_in),
        .load_ready(load_ready), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    mat_serialize #(.ROWS(1), .COLS(1), .WIDTH(8)) dut_1x1 (
        .clk(clk), .reset(reset), .load(s_load), .mat_in(s_mat),
        .load_ready(s_load_ready), .out_data(s_data), .out_row(s_row),
        .out_col(s_col), .out_last(s_last), .out_valid(s_valid),
        .out_ready(s_ready), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending-beat queue filled in emission order on an accepted load.
    typedef struct {
        logic [7:0] d;
        int         r;
        int         c;
        bit         last;
    } beat_t;

    beat_t exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            if (out_ready) void'(exp_q.pop_front());
        end else if (load) begin
`ifdef MAT_SERIALIZE_COL_MAJOR_EN
            for (int c = 0; c < COLS; c++)
                for (int r = 0; r < ROWS; r++)
                    exp_q.push_back('{mat_in[(r*COLS+c)*8 +: 8], r, c, (r == ROWS-1) && (c == COLS-1)});
`else
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    exp_q.push_back('{mat_in[(r*COLS+c)*8 +: 8], r, c, (r == ROWS-1) && (c == COLS-1)});
`endif
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0) begin
                chk("valid", out_valid, 1);
                chk("data", out_data, exp_q[0].d);
                chk("row", out_row, exp_q[0].r);
                chk("col", out_col, exp_q[0].c);
                chk("last", out_last, exp_q[0].last);
                chk("load_ready", load_ready, 0);
                chk("busy", busy, 1);
            end else begin
                chk("valid_idle", out_valid, 0);
                chk("last_idle", out_last, 0);
                chk("load_ready_idle", load_ready, 1);
                chk("busy_idle", busy, 0);
            end
        end
    end

    // Record every transfer the DUT actually makes, for literal sequence checks.
    logic [7:0] log_d[$];
    logic [2:0] log_tag[$];
    logic       log_last[$];

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            log_d.push_back(out_data);
            log_tag.push_back({out_row, out_col});
            log_last.push_back(out_last);
        end
    end

    logic [7:0] exp_seq [6];

    task automatic clear_log();
        log_d.delete();
        log_tag.delete();
        log_last.delete();
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, log_d.size(), 6);
        for (int i = 0; i < 6 && i < log_d.size(); i++) begin
            chk({nm, "_seq_data"}, log_d[i], exp_seq[i]);
            chk({nm, "_seq_last"}, log_last[i], (i == 5));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (!load_ready && k < 40) begin
            cyc();
            k++;
        end
        chk({nm, "_idle"}, load_ready, 1);
    endtask

    localparam logic [47:0] M = {8'h23, 8'h22, 8'h21, 8'h13, 8'h12, 8'h11};
    bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef MAT_SERIALIZE_COL_MAJOR_EN
        exp_seq = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
`else
        exp_seq = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
`endif
        reset = 1'b1; load = 1'b0; mat_in = '0; out_ready = 1'b0;
        s_load = 1'b0; s_mat = '0; s_ready = 1'b0;
        cyc(); cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tags", {out_row, out_col}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", load_ready, 1);
        reset = 1'b0;
        cyc();

        // Free-flowing stream
        clear_log();
        mat_in = M; load = 1'b1; out_ready = 1'b1;
        cyc();
        load = 1'b0;
        chk("t1_first_data", out_data, 8'h11);
        repeat (6) cyc();
        chk("t1_load_ready_after", load_ready, 1);
        check_log("t1");
        if (log_tag.size() == 6) begin
`ifdef MAT_SERIALIZE_COL_MAJOR_EN
            chk("t1_tag1", log_tag[1], 3'b100);
`else
            chk("t1_tag1", log_tag[1], 3'b001);
`endif
            chk("t1_tag5", log_tag[5], 3'b110);
        end
        cyc();

        // Stalled stream
        clear_log();
        load = 1'b1; out_ready = 1'b0;
        cyc();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            out_ready = pat[k];
            cyc();
        end
        out_ready = 1'b1;
        wait_idle("t2");
        check_log("t2");
        cyc();

        // Load and mat_in changes during SEND are ignored
        clear_log();
        mat_in = M; load = 1'b1; out_ready = 1'b1;
        cyc();
        load = 1'b0;
        cyc(); cyc();
        load = 1'b1; mat_in = {6{8'h77}};
        cyc();
        load = 1'b0;
        wait_idle("t4");
        check_log("t4");
        cyc(); cyc();
        chk("t4_no_queued_load", out_valid, 0);
        chk("t4_still_ready", load_ready, 1);

        // Asynchronous reset mid-stream
        mat_in = M; load = 1'b1; out_ready = 1'b1;
        cyc();
        load = 1'b0;
        cyc(); cyc(); cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_load_ready", load_ready, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_data", out_data, 0);
        cyc();
        reset = 1'b0;
        cyc();
        clear_log();
        mat_in = {6{8'hAA}}; load = 1'b1;
        cyc();
        load = 1'b0;
        chk("t5_new_tags", {out_row, out_col}, 0);
        chk("t5_new_data", out_data, 8'hAA);
        wait_idle("t5");
        exp_seq = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        check_log("t5");

        // 1x1 matrix
        s_mat = 8'h5A; s_load = 1'b1; s_ready = 1'b1;
        cyc();
        s_load = 1'b0;
        chk("s_valid", s_valid, 1);
        chk("s_data", s_data, 8'h5A);
        chk("s_last", s_last, 1);
        chk("s_busy", s_busy, 1);
        chk("s_load_ready", s_load_ready, 0);
        cyc();
        chk("s_valid_after", s_valid, 0);
        chk("s_last_after", s_last, 0);
        chk("s_load_ready_after", s_load_ready, 1);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
